// File: rtl/mznm_pkg.sv
// ---------------------------------------------------------------------------
// mznm_pkg
// Shared types and widths for the data memory responder slice.
//   state_t : responder FSM states (IDLE, WAIT, RESP)
//   req_t   : one latched processor request (operation, address, write data)
//   DATA_W  : width of one stored word and of the data buses
//   ADDR_W  : width of the processor word address
//   CNT_W   : width of the latency down-counter (LATENCY up to 15)
// ---------------------------------------------------------------------------
package mznm_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A write request wins over a read when both strobes are high, so a
  // single op bit is enough to describe what gets done in RESP.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Single-port word storage: synchronous write, registered read.
// Ports:
//   clk    : clock, all updates on the rising edge
//   reset  : asynchronous active-low reset, clears only the read register
//   en     : perform an access this edge
//   we     : 1 = write wdata to idx, 0 = read idx into rdata
//   idx    : word index into the array
//   wdata  : write data
//   rdata  : registered read data, holds until the next read access
// ---------------------------------------------------------------------------
module dmem_array
  import mznm_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage has no reset: contents survive a reset of the responder.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  // The read register only moves on a read access, so it doubles as the
  // "last completed read" value the processor sees.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Multi-cycle data memory slave for a simple processor. A request (MR/MW)
// is accepted in IDLE, held for LATENCY cycles, and completed in the RESP
// cycle with a one-cycle done pulse. The processor stalls on busy.
// Parameters:
//   DEPTH   : number of 16-bit words stored (power of two)
//   LATENCY : cycles from acceptance edge to the done cycle, 1..15
// Ports:
//   clk     : clock
//   reset   : asynchronous active-low reset
//   MR, MW  : read / write request strobes (write wins if both high)
//   addr    : word address
//   wdata   : write data
//   memData : data of the most recently completed read
//   busy    : request in flight (state != IDLE)
//   done    : one-cycle completion pulse
//   err     : one-cycle out-of-range pulse with done (bounds build only)
// Build option:
//   DMEM_BOUNDS_CHECK_EN : when defined, addresses >= DEPTH complete with an
//   err pulse and no array access; when undefined, addresses wrap modulo
//   DEPTH and the err port does not exist.
// ---------------------------------------------------------------------------
module data_mem_responder
  import mznm_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MR,
  input  logic              MW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] memData,
  output logic              busy,
  output logic              done
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int              IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LOAD_COUNT = CNT_W'(LATENCY - 1);

  state_t            state;
  logic [CNT_W-1:0]  count;
  req_t              lat_req;
  req_t              acc_req;
  logic              req_valid;
  logic              enter_resp;
  logic              arr_en;
  logic [IDX_W-1:0]  arr_idx;

  assign req_valid = MR || MW;
  assign busy      = (state != IDLE);

  // With LATENCY=1 the array is accessed on the acceptance edge itself,
  // before the request has been latched, so the live inputs are used while
  // idle and the latched copy otherwise.
  always_comb begin
    acc_req = lat_req;
    if (state == IDLE) begin
      acc_req.write = MW;
      acc_req.addr  = addr;
      acc_req.data  = wdata;
    end
  end

  // The edge that moves the FSM into RESP is the edge that performs the
  // array access; its registered read result is then visible during RESP.
  assign enter_resp = ((state == IDLE) && req_valid && (LATENCY == 1)) ||
                      ((state == WAIT) && (count == CNT_W'(1)));

  // Masking with DEPTH-1 gives addr modulo DEPTH for a power-of-two depth.
  assign arr_idx = IDX_W'(acc_req.addr & ADDR_W'(DEPTH - 1));

`ifdef DMEM_BOUNDS_CHECK_EN
  logic acc_in_range;
  assign acc_in_range = (32'(acc_req.addr) < 32'(DEPTH));
  // Gating with reset keeps a request from touching the array while reset
  // is held, which would otherwise be possible in IDLE.
  assign arr_en = enter_resp && reset && acc_in_range;
`else
  assign arr_en = enter_resp && reset;
`endif

  // Responder FSM: accept in IDLE, count down in WAIT, complete in RESP.
  // done (and err) are registered so they line up exactly with RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      lat_req <= '0;
      done    <= 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      done <= enter_resp;
`ifdef DMEM_BOUNDS_CHECK_EN
      err  <= enter_resp && !acc_in_range;
`endif
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            lat_req <= acc_req;
            count   <= LOAD_COUNT;
            state   <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (arr_en),
    .we    (acc_req.write),
    .idx   (arr_idx),
    .wdata (acc_req.data),
    .rdata (memData)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench for data_mem_responder: a LATENCY=2 instance (u0) and a
// LATENCY=1 instance (u1) share clock and reset. Inputs change and outputs
// are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  logic        clk;
  logic        reset;

  logic        mr0, mw0;
  logic [15:0] addr0, wdata0;
  logic [15:0] mem_data0;
  logic        busy0, done0;

  logic        mr1, mw1;
  logic [15:0] addr1, wdata1;
  logic [15:0] mem_data1;
  logic        busy1, done1;

`ifdef DMEM_BOUNDS_CHECK_EN
  logic        err0, err1;
`endif

  int vectors;
  int miscompares;

  data_mem_responder #(.DEPTH(1024), .LATENCY(2)) u0 (
    .clk     (clk),
    .reset   (reset),
    .MR      (mr0),
    .MW      (mw0),
    .addr    (addr0),
    .wdata   (wdata0),
    .memData (mem_data0),
    .busy    (busy0),
    .done    (done0)
`ifdef DMEM_BOUNDS_CHECK_EN
    ,
    .err     (err0)
`endif
  );

  data_mem_responder #(.DEPTH(1024), .LATENCY(1)) u1 (
    .clk     (clk),
    .reset   (reset),
    .MR      (mr1),
    .MW      (mw1),
    .addr    (addr1),
    .wdata   (wdata1),
    .memData (mem_data1),
    .busy    (busy1),
    .done    (done1)
`ifdef DMEM_BOUNDS_CHECK_EN
    ,
    .err     (err1)
`endif
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and step off it before touching signals.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Complete a LATENCY=2 transaction on u0 without checking anything.
  task automatic do_write0(input logic [15:0] a, input logic [15:0] d);
    mw0 = 1'b1; addr0 = a; wdata0 = d;
    tick();
    mw0 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    vectors++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || mem_data0 !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_u0: busy=%b done=%b memData=%h expected 0 0 0000", busy0, done0, mem_data0);
    end
    vectors++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || mem_data1 !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_u1: busy=%b done=%b memData=%h expected 0 0 0000", busy1, done1, mem_data1);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    mw0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'hBEEF;
    tick();
    mw0 = 1'b0;
    vectors++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wr_cycle1: busy=%b done=%b expected 1 0", busy0, done0);
    end
    tick();
    vectors++;
    if (busy0 !== 1'b1 || done0 !== 1'b1 || mem_data0 !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL wr_cycle2: busy=%b done=%b memData=%h expected 1 1 0000", busy0, done0, mem_data0);
    end
    tick();
    vectors++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wr_idle: busy=%b done=%b expected 0 0", busy0, done0);
    end
    mr0 = 1'b1; addr0 = 16'h0010;
    tick();
    mr0 = 1'b0;
    tick();
    vectors++;
    if (done0 !== 1'b1 || mem_data0 !== 16'hBEEF) begin
      miscompares++;
      $display("[TB] FAIL rd_done: done=%b memData=%h expected 1 beef", done0, mem_data0);
    end
    tick();
    tick();
    vectors++;
    if (busy0 !== 1'b0 || mem_data0 !== 16'hBEEF) begin
      miscompares++;
      $display("[TB] FAIL rd_hold: busy=%b memData=%h expected 0 beef", busy0, mem_data0);
    end
  endtask

  task automatic test_simultaneous();
    mr0 = 1'b1; mw0 = 1'b1; addr0 = 16'h0005; wdata0 = 16'h1234;
    tick();
    mr0 = 1'b0; mw0 = 1'b0;
    tick();
    vectors++;
    if (done0 !== 1'b1 || mem_data0 !== 16'hBEEF) begin
      miscompares++;
      $display("[TB] FAIL both_as_write: done=%b memData=%h expected 1 beef", done0, mem_data0);
    end
    tick();
    mr0 = 1'b1; addr0 = 16'h0005;
    tick();
    mr0 = 1'b0;
    tick();
    vectors++;
    if (mem_data0 !== 16'h1234) begin
      miscompares++;
      $display("[TB] FAIL both_readback: memData=%h expected 1234", mem_data0);
    end
    tick();
  endtask

  task automatic test_ignore_busy();
    mw0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'h1111;
    tick();
    // Change everything while the write is in flight.
    mw0 = 1'b0; mr0 = 1'b1; addr0 = 16'h0031; wdata0 = 16'h2222;
    tick();
    mr0 = 1'b0;
    tick();
    mr0 = 1'b1; addr0 = 16'h0030;
    tick();
    mr0 = 1'b0;
    tick();
    vectors++;
    if (mem_data0 !== 16'h1111) begin
      miscompares++;
      $display("[TB] FAIL ignore_busy: memData=%h expected 1111", mem_data0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    mr0 = 1'b1; addr0 = 16'h0010;
    tick();
    tick();
    tick();
    vectors++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_idle_gap: busy=%b done=%b expected 0 0", busy0, done0);
    end
    tick();
    mr0 = 1'b0;
    vectors++;
    if (busy0 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_reaccept: busy=%b expected 1", busy0);
    end
    tick();
    tick();
  endtask

  task automatic test_latency1();
    mw1 = 1'b1; addr1 = 16'h0040; wdata1 = 16'h7777;
    tick();
    mw1 = 1'b0;
    vectors++;
    if (busy1 !== 1'b1 || done1 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL lat1_wr_done: busy=%b done=%b expected 1 1", busy1, done1);
    end
    tick();
    vectors++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lat1_no_wait: busy=%b done=%b expected 0 0", busy1, done1);
    end
    mr1 = 1'b1; addr1 = 16'h0040;
    tick();
    mr1 = 1'b0;
    vectors++;
    if (done1 !== 1'b1 || mem_data1 !== 16'h7777) begin
      miscompares++;
      $display("[TB] FAIL lat1_rd: done=%b memData=%h expected 1 7777", done1, mem_data1);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    do_write0(16'h0020, 16'h0000);
    mw0 = 1'b1; addr0 = 16'h0020; wdata0 = 16'hDEAD;
    tick();
    mw0 = 1'b0;
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || mem_data0 !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL abort_reset: busy=%b done=%b memData=%h expected 0 0 0000", busy0, done0, mem_data0);
    end
    tick();
    reset = 1'b1;
    tick();
    mr0 = 1'b1; addr0 = 16'h0020;
    tick();
    mr0 = 1'b0;
    tick();
    vectors++;
    if (done0 !== 1'b1 || mem_data0 !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL abort_readback: done=%b memData=%h expected 1 0000", done0, mem_data0);
    end
    tick();
  endtask

`ifdef DMEM_BOUNDS_CHECK_EN
  task automatic test_bounds();
    do_write0(16'h0007, 16'h5A5A);
    mr0 = 1'b1; addr0 = 16'h0007;
    tick();
    mr0 = 1'b0;
    tick();
    tick();
    mr0 = 1'b1; addr0 = 16'h0400;
    tick();
    mr0 = 1'b0;
    tick();
    vectors++;
    if (done0 !== 1'b1 || err0 !== 1'b1 || mem_data0 !== 16'h5A5A) begin
      miscompares++;
      $display("[TB] FAIL bounds_err: done=%b err=%b memData=%h expected 1 1 5a5a", done0, err0, mem_data0);
    end
    tick();
    vectors++;
    if (err0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bounds_err_pulse: err=%b expected 0", err0);
    end
  endtask
`else
  task automatic test_wrap();
    do_write0(16'h0403, 16'hA5A5);
    mr0 = 1'b1; addr0 = 16'h0003;
    tick();
    mr0 = 1'b0;
    tick();
    vectors++;
    if (done0 !== 1'b1 || mem_data0 !== 16'hA5A5) begin
      miscompares++;
      $display("[TB] FAIL wrap_read: done=%b memData=%h expected 1 a5a5", done0, mem_data0);
    end
    tick();
  endtask
`endif

  // Test sequence.
  initial begin
    vectors = 0;
    miscompares = 0;
    mr0 = 1'b0; mw0 = 1'b0; addr0 = '0; wdata0 = '0;
    mr1 = 1'b0; mw1 = 1'b0; addr1 = '0; wdata1 = '0;
    test_reset();
    test_write_read();
    test_simultaneous();
    test_ignore_busy();
    test_back_to_back();
    test_latency1();
    test_reset_abort();
`ifdef DMEM_BOUNDS_CHECK_EN
    test_bounds();
`else
    test_wrap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
